// File: rtl/matmul_tile_scheduler.sv
// Walks the output tiles of C = A*B for a 4x4 systolic engine: clears PE accumulators
// per output tile, then launches the engine once per inner index k with tile addresses.
module matmul_tile_scheduler #(
  parameter int AWIDTH         = 10,
  parameter int STRIDE_WIDTH   = 8,
  parameter int MAX_TILES_LOG2 = 3,
  parameter int PE_CLR_CYCLES  = 2,
  parameter int GAP_CYCLES     = 1,
  parameter int TIMEOUT        = 1023
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_start,
  input  logic                      cfg_abort,
  input  logic [MAX_TILES_LOG2:0]   cfg_num_tiles,
  input  logic [AWIDTH-1:0]         cfg_base_a,
  input  logic [AWIDTH-1:0]         cfg_base_b,
  input  logic [AWIDTH-1:0]         cfg_base_c,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic                      mm_start,
  input  logic                      mm_done,
  output logic                      mm_pe_reset,
  output logic [AWIDTH-1:0]         mm_addr_a,
  output logic [AWIDTH-1:0]         mm_addr_b,
  output logic [AWIDTH-1:0]         mm_addr_c,
  output logic [STRIDE_WIDTH-1:0]   mm_stride_a,
  output logic [STRIDE_WIDTH-1:0]   mm_stride_b,
  output logic [STRIDE_WIDTH-1:0]   mm_stride_c,
  output logic [MAX_TILES_LOG2-1:0] tile_i,
  output logic [MAX_TILES_LOG2-1:0] tile_j,
  output logic [MAX_TILES_LOG2-1:0] tile_k
);

  localparam int NW = MAX_TILES_LOG2 + 1;
  localparam int IW = MAX_TILES_LOG2;
  localparam int CNT_MAX = (TIMEOUT > PE_CLR_CYCLES) ?
                           ((TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES) :
                           ((PE_CLR_CYCLES > GAP_CYCLES) ? PE_CLR_CYCLES : GAP_CYCLES);
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] PE_LAST  = CW'(PE_CLR_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [NW-1:0] N_MAX    = NW'(2 ** MAX_TILES_LOG2);

  typedef enum logic [2:0] {IDLE, PE_CLR, LAUNCH, WAIT, RELEASE, FINISH} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [IW-1:0]   i_reg, j_reg, k_reg, i_next, j_next, k_next;
  logic [NW-1:0]   n_reg, n_next;
  logic [AWIDTH-1:0] base_reg [3];
  logic [AWIDTH-1:0] base_next [3];
  logic [AWIDTH-1:0] addr_reg [3];
  logic            busy_reg, busy_next, done_reg, done_next, error_reg, error_next;
  logic            cfg_valid, i_last, j_last, k_last, load_addr;

  assign cfg_valid = (cfg_num_tiles != '0) && (cfg_num_tiles <= N_MAX);
  assign i_last    = ({1'b0, i_reg} == n_reg - NW'(1));
  assign j_last    = ({1'b0, j_reg} == n_reg - NW'(1));
  assign k_last    = ({1'b0, k_reg} == n_reg - NW'(1));

  always_comb begin
    state_next  = state_reg;
    i_next      = i_reg;
    j_next      = j_reg;
    k_next      = k_reg;
    n_next      = n_reg;
    base_next   = base_reg;
    busy_next   = busy_reg;
    done_next   = done_reg;
    error_next  = error_reg;
    mm_start    = 1'b0;
    mm_pe_reset = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cfg_start) begin
          done_next    = 1'b0;
          error_next   = 1'b0;
          i_next       = '0;
          j_next       = '0;
          k_next       = '0;
          n_next       = cfg_num_tiles;
          base_next[0] = cfg_base_a;
          base_next[1] = cfg_base_b;
          base_next[2] = cfg_base_c;
          if (cfg_valid) begin
            busy_next  = 1'b1;
            state_next = PE_CLR;
          end else begin
            error_next = 1'b1;
            busy_next  = 1'b0;
          end
        end
      end
      PE_CLR: begin
        mm_pe_reset = 1'b1;
        if (cnt_reg == PE_LAST) state_next = LAUNCH;
      end
      LAUNCH: state_next = WAIT;
      WAIT: begin
        mm_start = 1'b1;
        if (mm_done) begin
          state_next = RELEASE;
        end else if (cnt_reg == TO_LAST) begin
          error_next = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      RELEASE: begin
        if (cnt_reg == GAP_LAST) begin
          if (!k_last) begin
            k_next     = k_reg + IW'(1);
            state_next = LAUNCH;
          end else begin
            k_next = '0;
            if (!j_last) begin
              j_next     = j_reg + IW'(1);
              state_next = PE_CLR;
            end else begin
              j_next = '0;
              if (!i_last) begin
                i_next     = i_reg + IW'(1);
                state_next = PE_CLR;
              end else begin
                // Completion is flagged on entry to FINISH so it is visible there.
                i_next     = '0;
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = FINISH;
              end
            end
          end
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Abort discards anything decided above except leaving the job.
    if (cfg_abort) begin
      state_next = IDLE;
      i_next     = i_reg;
      j_next     = j_reg;
      k_next     = k_reg;
      n_next     = n_reg;
      base_next  = base_reg;
      busy_next  = 1'b0;
      done_next  = done_reg;
      error_next = error_reg;
    end
  end

  assign cnt_next  = (state_next == state_reg) ? cnt_reg + CW'(1) : '0;
  assign load_addr = (state_next == LAUNCH) && (state_reg != LAUNCH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      i_reg     <= '0;
      j_reg     <= '0;
      k_reg     <= '0;
      n_reg     <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      i_reg     <= i_next;
      j_reg     <= j_next;
      k_reg     <= k_next;
      n_reg     <= n_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      error_reg <= error_next;
    end
  end

  // Channel 0 = A (row i, col k), 1 = B (row k, col j), 2 = C (row i, col j).
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_addr
      logic [IW-1:0]     row, col;
      logic [AWIDTH-1:0] addr_next;
      assign row       = (gi == 1) ? k_next : i_next;
      assign col       = (gi == 0) ? k_next : j_next;
      assign addr_next = base_reg[gi] + ((AWIDTH'(row) * AWIDTH'(n_reg) + AWIDTH'(col)) << 2);
      always_ff @(posedge clk) begin
        if (reset) begin
          base_reg[gi] <= '0;
          addr_reg[gi] <= '0;
        end else begin
          base_reg[gi] <= base_next[gi];
          if (load_addr) addr_reg[gi] <= addr_next;
        end
      end
    end
  endgenerate

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign error       = error_reg;
  assign mm_addr_a   = addr_reg[0];
  assign mm_addr_b   = addr_reg[1];
  assign mm_addr_c   = addr_reg[2];
  assign mm_stride_a = STRIDE_WIDTH'(1);
  assign mm_stride_b = STRIDE_WIDTH'(1);
  assign mm_stride_c = STRIDE_WIDTH'(1);
  assign tile_i      = i_reg;
  assign tile_j      = j_reg;
  assign tile_k      = k_reg;

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Scoreboard bench: expected tile launches are queued per job and popped on each
// rising mm_start; a simple engine model answers mm_done 5 cycles after launch.
module tb_matmul_tile_scheduler;

  logic       clk = 1'b0;
  logic       reset, cfg_start, cfg_abort, mm_done;
  logic [3:0] cfg_num_tiles;
  logic [9:0] cfg_base_a, cfg_base_b, cfg_base_c;
  logic       busy, done, error, mm_start, mm_pe_reset;
  logic [9:0] mm_addr_a, mm_addr_b, mm_addr_c;
  logic [7:0] mm_stride_a, mm_stride_b, mm_stride_c;
  logic [2:0] tile_i, tile_j, tile_k;

  matmul_tile_scheduler dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_num_tiles(cfg_num_tiles), .cfg_base_a(cfg_base_a), .cfg_base_b(cfg_base_b),
    .cfg_base_c(cfg_base_c), .busy(busy), .done(done), .error(error),
    .mm_start(mm_start), .mm_done(mm_done), .mm_pe_reset(mm_pe_reset),
    .mm_addr_a(mm_addr_a), .mm_addr_b(mm_addr_b), .mm_addr_c(mm_addr_c),
    .mm_stride_a(mm_stride_a), .mm_stride_b(mm_stride_b), .mm_stride_c(mm_stride_c),
    .tile_i(tile_i), .tile_j(tile_j), .tile_k(tile_k)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] a;
    logic [9:0] b;
    logic [9:0] c;
    logic [2:0] k;
  } launch_t;

  launch_t exp_q[$];
  int      n_checks = 0;
  int      n_errors = 0;
  int      launches = 0;
  int      pe_episodes = 0;
  bit      eng_en = 1'b1;
  bit      prev_start = 1'b0;
  bit      clr_seen = 1'b0;
  int      pe_run = 0;
  launch_t mon_e;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic push_job(input int n, input int ba, input int bb, input int bc);
    launch_t e;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        for (int k = 0; k < n; k++) begin
          e.a = 10'((ba + (i * n + k) * 4) % 1024);
          e.b = 10'((bb + (k * n + j) * 4) % 1024);
          e.c = 10'((bc + (i * n + j) * 4) % 1024);
          e.k = 3'(k);
          exp_q.push_back(e);
        end
  endtask

  task automatic start_job(input int n, input int ba, input int bb, input int bc);
    cfg_num_tiles = 4'(n);
    cfg_base_a = 10'(ba);
    cfg_base_b = 10'(bb);
    cfg_base_c = 10'(bc);
    @(posedge clk); #1 cfg_start = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0;
    $display("start n=%0d A=%0d B=%0d C=%0d", n, ba, bb, bc);
  endtask

  task automatic wait_done(input int limit);
    int c = 0;
    while (done !== 1'b1 && c < limit) begin
      @(negedge clk);
      c++;
    end
    check_eq("done_seen", done, 1);
  endtask

  task automatic wait_launches(input int target, input int limit);
    int c = 0;
    while (launches < target && c < limit) begin
      @(negedge clk);
      c++;
    end
    check_eq("launch_reached", (launches >= target) ? 1 : 0, 1);
  endtask

  // Engine model
  initial begin
    mm_done = 1'b0;
    forever begin
      do @(posedge clk); while (mm_start !== 1'b1);
      if (eng_en) begin
        repeat (4) @(posedge clk);
        #1 mm_done = 1'b1;
        @(posedge clk);
        #1 mm_done = 1'b0;
      end
      while (mm_start === 1'b1) @(posedge clk);
    end
  end

  // Launch monitor / scoreboard consumer
  initial begin
    forever begin
      @(negedge clk);
      if (mm_pe_reset === 1'b1) begin
        pe_run++;
      end else if (pe_run != 0) begin
        check_eq("pe_clr_len", pe_run, 2);
        pe_episodes++;
        clr_seen = 1'b1;
        pe_run = 0;
      end
      if (mm_start === 1'b1 && !prev_start) begin
        launches++;
        if (exp_q.size() == 0) begin
          check_eq("sb_underflow", 32'(exp_q.size()), 1);
        end else begin
          mon_e = exp_q.pop_front();
          $display("launch A=%0d B=%0d C=%0d k=%0d", mm_addr_a, mm_addr_b, mm_addr_c, tile_k);
          check_eq("addr_a", mm_addr_a, mon_e.a);
          check_eq("addr_b", mm_addr_b, mon_e.b);
          check_eq("addr_c", mm_addr_c, mon_e.c);
          check_eq("tile_k", tile_k, mon_e.k);
          if (mon_e.k == 3'd0) check_eq("clr_before_k0", clr_seen, 1);
          clr_seen = 1'b0;
        end
      end
      prev_start = (mm_start === 1'b1);
    end
  end

  initial begin
    int l0, p0, wcyc;
    reset = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0;
    cfg_num_tiles = '0; cfg_base_a = '0; cfg_base_b = '0; cfg_base_c = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_mm_start", mm_start, 0);
    check_eq("rst_pe_reset", mm_pe_reset, 0);
    check_eq("rst_addr_c", mm_addr_c, 0);
    check_eq("rst_stride_b", mm_stride_b, 1);

    // n=1 single launch
    l0 = launches; p0 = pe_episodes;
    push_job(1, 0, 16, 32);
    start_job(1, 0, 16, 32);
    @(negedge clk);
    check_eq("busy_after_start", busy, 1);
    wait_done(200);
    check_eq("n1_busy_end", busy, 0);
    check_eq("n1_error", error, 0);
    check_eq("n1_launches", launches - l0, 1);
    check_eq("n1_pe_episodes", pe_episodes - p0, 1);
    check_eq("n1_sb_empty", exp_q.size(), 0);

    // n=2 with a stray cfg_start mid-job
    l0 = launches; p0 = pe_episodes;
    push_job(2, 0, 64, 128);
    start_job(2, 0, 64, 128);
    wait_launches(l0 + 2, 200);
    start_job(1, 500, 500, 500);
    wait_done(2000);
    check_eq("n2_launches", launches - l0, 8);
    check_eq("n2_pe_episodes", pe_episodes - p0, 4);
    check_eq("n2_sb_empty", exp_q.size(), 0);

    // engine never answers -> timeout
    eng_en = 1'b0;
    push_job(1, 0, 0, 0);
    start_job(1, 0, 0, 0);
    wcyc = 0;
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      if (mm_start === 1'b1) wcyc++;
      if (error === 1'b1) break;
    end
    check_eq("to_error", error, 1);
    check_eq("to_wait_cycles", wcyc, 1023);
    check_eq("to_mm_start", mm_start, 0);
    check_eq("to_busy", busy, 0);
    check_eq("to_done", done, 0);
    eng_en = 1'b1;

    // abort during the 3rd WAIT, then a clean n=1 job
    l0 = launches;
    push_job(2, 0, 64, 128);
    start_job(2, 0, 64, 128);
    wait_launches(l0 + 3, 300);
    @(posedge clk); #1 cfg_abort = 1'b1;
    @(posedge clk); #1 cfg_abort = 1'b0;
    @(negedge clk);
    check_eq("abort_mm_start", mm_start, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_error", error, 0);
    check_eq("abort_done", done, 0);
    exp_q.delete();
    repeat (10) @(negedge clk);
    l0 = launches;
    push_job(1, 100, 200, 300);
    start_job(1, 100, 200, 300);
    wait_done(200);
    check_eq("post_abort_launches", launches - l0, 1);

    // invalid tile counts
    l0 = launches; p0 = pe_episodes;
    start_job(0, 0, 0, 0);
    @(negedge clk);
    check_eq("n0_error", error, 1);
    check_eq("n0_busy", busy, 0);
    check_eq("n0_done_cleared", done, 0);
    repeat (20) @(negedge clk);
    check_eq("n0_no_launch", launches - l0, 0);
    check_eq("n0_no_pe_clr", pe_episodes - p0, 0);
    start_job(9, 0, 0, 0);
    @(negedge clk);
    check_eq("n9_error", error, 1);
    check_eq("n9_busy", busy, 0);
    repeat (20) @(negedge clk);
    check_eq("n9_no_launch", launches - l0, 0);

    // C address wraps modulo 1024
    l0 = launches;
    push_job(2, 0, 0, 1020);
    start_job(2, 0, 0, 1020);
    wait_done(2000);
    check_eq("wrap_error_cleared", error, 0);
    check_eq("wrap_launches", launches - l0, 8);
    check_eq("wrap_sb_empty", exp_q.size(), 0);

    // reset mid-job
    l0 = launches;
    push_job(2, 100, 200, 300);
    start_job(2, 100, 200, 300);
    wait_launches(l0 + 2, 200);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_mm_start", mm_start, 0);
    check_eq("mid_rst_addr_a", mm_addr_a, 0);
    check_eq("mid_rst_addr_c", mm_addr_c, 0);
    check_eq("mid_rst_tile_k", tile_k, 0);
    exp_q.delete();
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/matmul_tile_scheduler.md
Name: matmul_tile_scheduler

Overview:
- Sequences the 4x4 systolic matmul engine over square matrices of N = 4*num_tiles elements per side, computing C = A*B one 4x4 output tile at a time.
- For each output tile (i,j), it clears the PE accumulators, then launches the engine once per inner index k with A-tile (i,k) and B-tile (k,j) addresses.
- Sits between the APB register block (config/start/done) and the matmul engine's start/done/address/stride/pe_reset inputs.

Parameters:
- AWIDTH, 10, RAM address width.
- STRIDE_WIDTH, 8, engine stride width.
- MAX_TILES_LOG2, 3, num_tiles range 1..2^MAX_TILES_LOG2 (default 8).
- PE_CLR_CYCLES, 2, cycles mm_pe_reset is held per output tile.
- GAP_CYCLES, 1, cycles mm_start is low between launches.
- TIMEOUT, 1023, maximum WAIT cycles before error.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cfg_start  in  1  single-cycle request to begin a job
- cfg_abort  in  1  stop the current job immediately
- cfg_num_tiles  in  MAX_TILES_LOG2+1  tiles per matrix side
- cfg_base_a / cfg_base_b / cfg_base_c  in  AWIDTH  matrix base addresses
- busy  out  1  job in progress
- done  out  1  sticky job completion flag
- error  out  1  sticky timeout flag
- mm_start  out  1  engine start (level)
- mm_done  in  1  engine done pulse/level
- mm_pe_reset  out  1  PE accumulator clear
- mm_addr_a / mm_addr_b / mm_addr_c  out  AWIDTH  tile addresses
- mm_stride_a / mm_stride_b / mm_stride_c  out  STRIDE_WIDTH  always 1
- tile_i / tile_j / tile_k  out  MAX_TILES_LOG2  current indices (debug)

Behaviour:
- Reset: state=IDLE; busy, done, error, mm_start, mm_pe_reset = 0; addresses and indices = 0; strides = 1.
- Tile layout: tile (r,c) of any matrix occupies 4 consecutive words at base + (r*num_tiles + c)*4.
  - mm_addr_a = base_a + (i*n + k)*4.
  - mm_addr_b = base_b + (k*n + j)*4.
  - mm_addr_c = base_c + (i*n + j)*4.
  - All address arithmetic is modulo 2^AWIDTH (wraps silently).
  - Addresses are registered and stable from LAUNCH until the following RELEASE completes.
- States: IDLE, PE_CLR, LAUNCH, WAIT, RELEASE, FINISH.
- IDLE, on cfg_start=1:
  - Latch config; clear done and error; i=j=k=0; busy=1.
  - If cfg_num_tiles==0 or > 2^MAX_TILES_LOG2: set error=1, stay IDLE, busy=0.
  - Otherwise go to PE_CLR.
- PE_CLR: mm_pe_reset=1 for exactly PE_CLR_CYCLES cycles, then LAUNCH.
- LAUNCH: one cycle with addresses updated and mm_start=0, then WAIT.
- WAIT: mm_start=1; the cycle counter increments each cycle.
  - On mm_done=1: go to RELEASE; mm_start drops on the next cycle.
  - If the counter reaches TIMEOUT: set error=1, mm_start=0, busy=0, go to IDLE.
- RELEASE: mm_start=0 for GAP_CYCLES cycles, then advance the indices.
  - k++. On k wrap (k==n-1): k=0, j++. On j wrap: j=0, i++.
  - If all of i, j, k wrapped: go to FINISH.
  - Else if k wrapped: go to PE_CLR (new output tile).
  - Else: go to LAUNCH (same output tile, accumulate).
- FINISH: done=1, busy=0, go to IDLE. done stays high until the next accepted cfg_start or reset.
- Total engine launches per job = n^3; PE_CLR episodes = n^2.
- cfg_start while busy: ignored with no side effects.
- cfg_abort, in any state:
  - Next state is IDLE; mm_start=0, mm_pe_reset=0, busy=0.
  - done and error are unchanged.
  - cfg_abort has priority over a simultaneous cfg_start and over mm_done.
- mm_done outside WAIT: ignored.
- reset mid-job returns every output to its reset value on the next edge.

Test Plan:
- n=1, bases A=0, B=16, C=32; mm_done driven 5 cycles after mm_start rises -> one PE_CLR of 2 cycles, one launch with addresses 0/16/32, done=1 one cycle after RELEASE, busy=0.
- n=2, bases 0/64/128 -> 8 launches. A-address sequence: 0,4,0,4,8,12,8,12. B-address sequence: 64,72,68,76,64,72,68,76. C-address sequence: 128,128,132,132,136,136,140,140. 4 PE_CLR pulses, each preceding k=0.
- n=1, mm_done never asserted -> error=1 after 1023 WAIT cycles, mm_start=0, busy=0, done=0.
- n=2, cfg_abort asserted during the 3rd WAIT -> IDLE next cycle with mm_start=0; a subsequent cfg_start with n=1 completes normally.
- cfg_num_tiles=0 -> error=1, no mm_start. cfg_num_tiles=9 -> error=1. cfg_start pulsed mid-job -> no index or address disturbance.
- base_c=1020, n=2 -> mm_addr_c sequence wraps: 1020, 0, 4, 8.
